capture_arbiter: RTL and testbench

//  Packet-granular 2:1 round-robin AXI4-Stream arbiter for the packet-capture path.

---
 rtl/capture_arbiter.sv | 146 ++++++++++++++
 tb/tb_capture_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_arbiter.sv
// Packet-granular 2:1 round-robin AXI4-Stream arbiter for the capture path.
// Port 1 is forwarded or drained depending on capture_en sampled at IDLE.
module capture_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
  input  logic                              s_axis_tvalid_0,
  output logic                              s_axis_tready_0,
  input  logic                              s_axis_tlast_0,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
  input  logic                              s_axis_tvalid_1,
  output logic                              s_axis_tready_1,
  input  logic                              s_axis_tlast_1,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,

  input  logic                              capture_en,
  output logic [C_CNT_WIDTH-1:0]            pkt_cnt_0,
  output logic [C_CNT_WIDTH-1:0]            pkt_cnt_1,
  output logic [C_CNT_WIDTH-1:0]            drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PASS0,
    PASS1,
    DROP1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_grant_q;
  logic   last_grant_d;
  logic   inc_0;
  logic   inc_1;
  logic   inc_drop;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    inc_0           = 1'b0;
    inc_1           = 1'b0;
    inc_drop        = 1'b0;
    s_axis_tready_0 = 1'b0;
    s_axis_tready_1 = 1'b0;
    m_axis_tvalid   = 1'b0;
    m_axis_tdata    = s_axis_tdata_0;
    m_axis_tstrb    = s_axis_tstrb_0;
    m_axis_tuser    = s_axis_tuser_0;
    m_axis_tlast    = s_axis_tlast_0;

    unique case (state_q)
      IDLE: begin
        // Contention goes to the port that did not win last time.
        if (s_axis_tvalid_0 &&
            (!s_axis_tvalid_1 || last_grant_q)) begin
          state_d = PASS0;
        end else if (s_axis_tvalid_1) begin
          state_d = capture_en ? PASS1 : DROP1;
        end
      end

      PASS0: begin
        m_axis_tvalid   = s_axis_tvalid_0;
        s_axis_tready_0 = m_axis_tready;
        if (s_axis_tvalid_0 && m_axis_tready &&
            s_axis_tlast_0) begin
          inc_0        = 1'b1;
          last_grant_d = 1'b0;
          state_d      = IDLE;
        end
      end

      PASS1: begin
        m_axis_tdata    = s_axis_tdata_1;
        m_axis_tstrb    = s_axis_tstrb_1;
        m_axis_tuser    = s_axis_tuser_1;
        m_axis_tlast    = s_axis_tlast_1;
        m_axis_tvalid   = s_axis_tvalid_1;
        s_axis_tready_1 = m_axis_tready;
        if (s_axis_tvalid_1 && m_axis_tready &&
            s_axis_tlast_1) begin
          inc_1        = 1'b1;
          last_grant_d = 1'b1;
          state_d      = IDLE;
        end
      end

      DROP1: begin
        s_axis_tready_1 = 1'b1;
        if (s_axis_tvalid_1 && s_axis_tlast_1) begin
          inc_drop     = 1'b1;
          last_grant_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
      drop_cnt  <= '0;
    end else begin
      if (inc_0)
        pkt_cnt_0 <= pkt_cnt_0 + C_CNT_WIDTH'(1);
      if (inc_1)
        pkt_cnt_1 <= pkt_cnt_1 + C_CNT_WIDTH'(1);
      if (inc_drop)
        drop_cnt  <= drop_cnt + C_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_capture_arbiter.sv
// Randomized bench for capture_arbiter against a packet-level
// round-robin reference model.
module tb_capture_arbiter;

  localparam int DW = 32;
  localparam int UW = 16;
  localparam int SW = DW / 8;
  localparam int CW = 4;
  localparam int BUDGET = 3000;

  typedef struct packed {
    logic          l;
    logic [UW-1:0] u;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          axi_reset = 1'b0;
  logic [DW-1:0] s_axis_tdata_0 = '0;
  logic [SW-1:0] s_axis_tstrb_0 = '0;
  logic [UW-1:0] s_axis_tuser_0 = '0;
  logic          s_axis_tvalid_0 = 1'b0;
  logic          s_axis_tready_0;
  logic          s_axis_tlast_0 = 1'b0;
  logic [DW-1:0] s_axis_tdata_1 = '0;
  logic [SW-1:0] s_axis_tstrb_1 = '0;
  logic [UW-1:0] s_axis_tuser_1 = '0;
  logic          s_axis_tvalid_1 = 1'b0;
  logic          s_axis_tready_1;
  logic          s_axis_tlast_1 = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          capture_en = 1'b0;
  logic [CW-1:0] pkt_cnt_0;
  logic [CW-1:0] pkt_cnt_1;
  logic [CW-1:0] drop_cnt;

  capture_arbiter #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .C_CNT_WIDTH         (CW)
  ) dut (
    .axi_aclk       (clk),
    .axi_reset      (axi_reset),
    .s_axis_tdata_0 (s_axis_tdata_0),
    .s_axis_tstrb_0 (s_axis_tstrb_0),
    .s_axis_tuser_0 (s_axis_tuser_0),
    .s_axis_tvalid_0(s_axis_tvalid_0),
    .s_axis_tready_0(s_axis_tready_0),
    .s_axis_tlast_0 (s_axis_tlast_0),
    .s_axis_tdata_1 (s_axis_tdata_1),
    .s_axis_tstrb_1 (s_axis_tstrb_1),
    .s_axis_tuser_1 (s_axis_tuser_1),
    .s_axis_tvalid_1(s_axis_tvalid_1),
    .s_axis_tready_1(s_axis_tready_1),
    .s_axis_tlast_1 (s_axis_tlast_1),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .capture_en     (capture_en),
    .pkt_cnt_0      (pkt_cnt_0),
    .pkt_cnt_1      (pkt_cnt_1),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  beat_t q0[$];
  beat_t q1[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    exp_c0, exp_c1, exp_cd;
  int    first_beat_cyc;
  int    viol;
  bit    timed_out;
  int    nbad;

  task automatic clear_all();
    q0.delete();
    q1.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic gen_pkt(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DW'($urandom);
      b.s = SW'($urandom);
      b.u = UW'($urandom);
      b.l = (i == len - 1);
      if (port == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  // Whole-packet round robin: port 0 first after reset, a port-1
  // turn is either forwarded or dropped, never interleaved.
  task automatic build_model(input bit cap, input bit cap_fall);
    int i0 = 0;
    int i1 = 0;
    bit lg = 1'b1;
    bit pick;
    bit fwd;
    bit cap_cur = cap;
    exp_q.delete();
    exp_c0 = 0;
    exp_c1 = 0;
    exp_cd = 0;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) pick = !lg;
      else pick = (i0 < q0.size()) ? 1'b0 : 1'b1;
      if (!pick) begin
        do begin
          exp_q.push_back(q0[i0]);
          i0++;
        end while (!q0[i0-1].l);
        exp_c0++;
      end else begin
        fwd = cap_cur;
        do begin
          if (fwd) exp_q.push_back(q1[i1]);
          i1++;
        end while (!q1[i1-1].l);
        if (fwd) exp_c1++;
        else exp_cd++;
        if (cap_fall) cap_cur = 1'b0;
      end
      lg = pick;
    end
  endtask

  function automatic int diff_beats();
    int n;
    int m;
    n = (got_q.size() > exp_q.size()) ?
        got_q.size() - exp_q.size() :
        exp_q.size() - got_q.size();
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic drive_inputs(input int i0, input int i1,
                              input int cyc, input int tr_mode,
                              input int gap_pct);
    beat_t b;
    bit    mid;
    b = '0;
    s_axis_tvalid_0 = 1'b0;
    if (i0 < q0.size()) begin
      b = q0[i0];
      mid = (i0 > 0) && !q0[i0-1].l;
      s_axis_tvalid_0 = !(mid && ($urandom_range(99) < gap_pct));
    end
    {s_axis_tlast_0, s_axis_tuser_0,
     s_axis_tstrb_0, s_axis_tdata_0} = b;
    b = '0;
    s_axis_tvalid_1 = 1'b0;
    if (i1 < q1.size()) begin
      b = q1[i1];
      mid = (i1 > 0) && !q1[i1-1].l;
      s_axis_tvalid_1 = !(mid && ($urandom_range(99) < gap_pct));
    end
    {s_axis_tlast_1, s_axis_tuser_1,
     s_axis_tstrb_1, s_axis_tdata_1} = b;
    case (tr_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ($urandom_range(99) < 70);
      default: m_axis_tready = ((cyc % 2) == 1);
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 axi_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 axi_reset = 1'b0;
  endtask

  task automatic run_traffic(input int tr_mode, input int gap_pct,
                             input bit cap, input bit cap_fall);
    int i0 = 0;
    int i1 = 0;
    int cyc = 0;
    bit b0, b1, fall_now;
    got_q.delete();
    first_beat_cyc = -1;
    viol = 0;
    timed_out = 1'b0;
    capture_en = cap;
    drive_inputs(i0, i1, cyc, tr_mode, gap_pct);
    while ((i0 < q0.size() || i1 < q1.size()) && cyc < BUDGET) begin
      @(negedge clk);
      b0 = s_axis_tvalid_0 && s_axis_tready_0;
      b1 = s_axis_tvalid_1 && s_axis_tready_1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        got_q.push_back({m_axis_tlast, m_axis_tuser,
                         m_axis_tstrb, m_axis_tdata});
      end
      if (!cap && s_axis_tready_1 && m_axis_tvalid) viol++;
      fall_now = cap_fall && b1 && capture_en;
      @(posedge clk);
      #1;
      if (b0) i0++;
      if (b1) i1++;
      if (fall_now) capture_en = 1'b0;
      cyc++;
      drive_inputs(i0, i1, cyc, tr_mode, gap_pct);
    end
    timed_out = (cyc >= BUDGET);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_all();
    s_axis_tvalid_0 = 1'b1;
    s_axis_tvalid_1 = 1'b1;
    s_axis_tlast_0 = 1'b0;
    s_axis_tlast_1 = 1'b0;
    m_axis_tready = 1'b1;
    capture_en = 1'b1;
    @(posedge clk);
    #1 axi_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_axis_tready_0, s_axis_tready_1, m_axis_tvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b expected 000",
               {s_axis_tready_0, s_axis_tready_1, m_axis_tvalid});
    end
    @(posedge clk);
    #1 axi_reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pkt_cnt_0, pkt_cnt_1, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h/%h/%h expected 0/0/0",
               pkt_cnt_0, pkt_cnt_1, drop_cnt);
    end
    n_checks++;
    if ({s_axis_tready_0, s_axis_tready_1, m_axis_tvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle_cycle: got %b expected 000",
               {s_axis_tready_0, s_axis_tready_1, m_axis_tvalid});
    end
    @(negedge clk);
    n_checks++;
    if ({s_axis_tready_0, s_axis_tready_1, m_axis_tvalid} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected 101",
               {s_axis_tready_0, s_axis_tready_1, m_axis_tvalid});
    end
  endtask

  task automatic test_port0_only();
    clear_all();
    gen_pkt(0, 3);
    build_model(1'b1, 1'b0);
    do_reset();
    run_traffic(0, 0, 1'b1, 1'b0);
    nbad = diff_beats();
    n_checks++;
    if (nbad !== 0 || timed_out) begin
      n_fail++;
      $display("FAIL p0_beats: got %0d bad beats (timeout %0d) expected 0",
               nbad, timed_out);
    end
    n_checks++;
    if (first_beat_cyc !== 1) begin
      n_fail++;
      $display("FAIL p0_latency: got cycle %0d expected 1", first_beat_cyc);
    end
    n_checks++;
    if (pkt_cnt_0 !== CW'(exp_c0)) begin
      n_fail++;
      $display("FAIL p0_count: got %0d expected %0d", pkt_cnt_0, exp_c0);
    end
  endtask

  task automatic test_round_robin();
    clear_all();
    for (int k = 0; k < 2; k++) begin
      gen_pkt(0, 2);
      gen_pkt(1, 2);
    end
    build_model(1'b1, 1'b0);
    do_reset();
    run_traffic(0, 0, 1'b1, 1'b0);
    nbad = diff_beats();
    n_checks++;
    if (nbad !== 0 || timed_out) begin
      n_fail++;
      $display("FAIL rr_order: got %0d bad beats (timeout %0d) expected 0",
               nbad, timed_out);
    end
    n_checks++;
    if ({pkt_cnt_0, pkt_cnt_1} !== {CW'(2), CW'(2)}) begin
      n_fail++;
      $display("FAIL rr_counts: got %0d/%0d expected 2/2",
               pkt_cnt_0, pkt_cnt_1);
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    gen_pkt(1, 4);
    build_model(1'b1, 1'b0);
    do_reset();
    run_traffic(2, 0, 1'b1, 1'b0);
    nbad = diff_beats();
    n_checks++;
    if (nbad !== 0 || timed_out) begin
      n_fail++;
      $display("FAIL bp_beats: got %0d bad beats (timeout %0d) expected 0",
               nbad, timed_out);
    end
    n_checks++;
    if (pkt_cnt_1 !== CW'(1)) begin
      n_fail++;
      $display("FAIL bp_count: got %0d expected 1", pkt_cnt_1);
    end
  endtask

  task automatic test_drop();
    clear_all();
    gen_pkt(0, 2);
    gen_pkt(1, 5);
    gen_pkt(0, 3);
    build_model(1'b0, 1'b0);
    do_reset();
    run_traffic(1, 20, 1'b0, 1'b0);
    nbad = diff_beats();
    n_checks++;
    if (nbad !== 0 || timed_out) begin
      n_fail++;
      $display("FAIL drop_stream: got %0d bad beats (timeout %0d) expected 0",
               nbad, timed_out);
    end
    n_checks++;
    if ({drop_cnt, pkt_cnt_1, pkt_cnt_0} !==
        {CW'(1), CW'(0), CW'(2)}) begin
      n_fail++;
      $display("FAIL drop_counts: got d%0d p1 %0d p0 %0d expected d1 p1 0 p0 2",
               drop_cnt, pkt_cnt_1, pkt_cnt_0);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL drop_mvalid: got %0d cycles with m_axis_tvalid expected 0",
               viol);
    end
  endtask

  task automatic test_capture_fall();
    clear_all();
    gen_pkt(1, 5);
    build_model(1'b1, 1'b1);
    do_reset();
    run_traffic(0, 0, 1'b1, 1'b1);
    nbad = diff_beats();
    n_checks++;
    if (nbad !== 0 || timed_out) begin
      n_fail++;
      $display("FAIL fall_beats: got %0d bad beats (timeout %0d) expected 0",
               nbad, timed_out);
    end
    n_checks++;
    if ({pkt_cnt_1, drop_cnt} !== {CW'(1), CW'(0)}) begin
      n_fail++;
      $display("FAIL fall_counts: got p1 %0d d%0d expected p1 1 d0",
               pkt_cnt_1, drop_cnt);
    end
  endtask

  task automatic test_wrap();
    clear_all();
    for (int k = 0; k < 16; k++)
      gen_pkt(0, $urandom_range(3, 1));
    build_model(1'b1, 1'b0);
    do_reset();
    run_traffic(1, 20, 1'b1, 1'b0);
    nbad = diff_beats();
    n_checks++;
    if (nbad !== 0 || timed_out) begin
      n_fail++;
      $display("FAIL wrap_beats: got %0d bad beats (timeout %0d) expected 0",
               nbad, timed_out);
    end
    n_checks++;
    if (pkt_cnt_0 !== CW'(0)) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d expected 0", pkt_cnt_0);
    end
  endtask

  task automatic test_random();
    bit cap;
    for (int it = 0; it < 6; it++) begin
      clear_all();
      for (int k = 0; k < $urandom_range(4, 0); k++)
        gen_pkt(0, $urandom_range(6, 1));
      for (int k = 0; k < $urandom_range(4, 0); k++)
        gen_pkt(1, $urandom_range(6, 1));
      cap = $urandom_range(1, 0);
      build_model(cap, 1'b0);
      do_reset();
      run_traffic(1, 30, cap, 1'b0);
      nbad = diff_beats();
      n_checks++;
      if (nbad !== 0 || timed_out) begin
        n_fail++;
        $display("FAIL rand%0d_stream: got %0d bad beats (timeout %0d) expected 0",
                 it, nbad, timed_out);
      end
      n_checks++;
      if ({pkt_cnt_0, pkt_cnt_1, drop_cnt} !==
          {CW'(exp_c0), CW'(exp_c1), CW'(exp_cd)}) begin
        n_fail++;
        $display("FAIL rand%0d_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 it, pkt_cnt_0, pkt_cnt_1, drop_cnt,
                 exp_c0, exp_c1, exp_cd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_port0_only();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_capture_fall();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
